// File: rtl/pixel_stream_pkg.sv
// Shared pixel-stream types: reader FSM state encoding and
// default video geometry (RGB888, 640x480 active).
package pixel_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } rd_state_t;

    localparam int PIX_WIDTH = 24;
    localparam int PIX_H_ACT = 640;
    localparam int PIX_V_ACT = 480;

endpackage

// File: rtl/pixel_skid_buf.sv
// Two-entry pixel buffer with sof/eol sideband.
// Ports: clk, rst (async, active high); wr_en/wr_data/wr_sof/wr_eol
// capture side; rd_en pop request (ignored when empty);
// rd_valid/rd_data/rd_sof/rd_eol head entry; count occupancy 0..2.
module pixel_skid_buf #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_sof,
    input  logic             wr_eol,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_sof,
    output logic             rd_eol,
    output logic [1:0]       count
);

    logic [WIDTH+1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_rd;
    logic [WIDTH+1:0] head;

    assign do_rd    = rd_en && (count != 2'd0);
    assign rd_valid = (count != 2'd0);
    assign head     = mem[rd_ptr];
    assign rd_data  = head[WIDTH-1:0];
    assign rd_eol   = head[WIDTH] & rd_valid;
    assign rd_sof   = head[WIDTH+1] & rd_valid;

    // The caller never writes when full, so wr_en is not gated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= {wr_sof, wr_eol, wr_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (do_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({wr_en, do_rd})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_pixel_reader.sv
// Pops pixels from a 1-cycle-latency FIFO and streams them out with
// valid/ready plus frame tags (sof on x=y=0, eol on x=H_ACT-1).
// Ports: clk, rst (async, active high); en run enable; fifo_empty,
// fifo_dout, fifo_rd_en FIFO side; pix_data/pix_valid/pix_ready/
// pix_sof/pix_eol stream side; busy activity flag.
// Optional: define FIFO_PIXEL_READER_STALL_CNT_EN to add stall_cnt,
// a saturating 16-bit count of cycles with pix_valid=1, pix_ready=0.
module fifo_pixel_reader
    import pixel_stream_pkg::*;
#(
    parameter int WIDTH = PIX_WIDTH,
    parameter int H_ACT = PIX_H_ACT,
    parameter int V_ACT = PIX_V_ACT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_sof,
    output logic             pix_eol,
`ifdef FIFO_PIXEL_READER_STALL_CNT_EN
    output logic [15:0]      stall_cnt,
`endif
    output logic             busy
);

    localparam int XW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int YW = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACT - 1);

    rd_state_t     state;
    rd_state_t     state_nxt;
    logic          in_flight;
    logic [1:0]    occ;
    logic          pop;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic          x_wrap;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          wr_sof;
    logic          wr_eol;

    assign pop = pix_valid & pix_ready;

    // Credit the pop happening this cycle so a steady stream can
    // issue a read every cycle without ever overfilling the buffer.
    assign fifo_rd_en = (state == RUN) && !fifo_empty &&
        (({1'b0, occ} + {2'b0, in_flight}) <
         (3'd2 + {2'b0, pop}));

    assign busy = (state != IDLE) || (occ != 2'd0) || in_flight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_flight <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_flight <= fifo_rd_en;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (en) state_nxt = RUN;
            RUN:  if (!en) state_nxt = STOP;
            STOP: begin
                if (en)
                    state_nxt = RUN;
                else if (occ == 2'd0 && !in_flight)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output position advance with line/frame wrap.
    always_comb begin
        x_wrap = (x == X_LAST);
        nx     = x_wrap ? '0 : x + 1'b1;
        ny     = y;
        if (x_wrap)
            ny = (y == Y_LAST) ? '0 : y + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (pop) begin
            x <= nx;
            y <= ny;
        end
    end

    // A captured pixel sits behind every entry already buffered.
    // Occupancy is at most 1 on a capture, so its position is
    // either the current head position or the one after it.
    always_comb begin
        cx     = (occ != 2'd0) ? nx : x;
        cy     = (occ != 2'd0) ? ny : y;
        wr_sof = (cx == '0) && (cy == '0);
        wr_eol = (cx == X_LAST);
    end

    pixel_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (in_flight),
        .wr_data  (fifo_dout),
        .wr_sof   (wr_sof),
        .wr_eol   (wr_eol),
        .rd_en    (pix_ready),
        .rd_valid (pix_valid),
        .rd_data  (pix_data),
        .rd_sof   (pix_sof),
        .rd_eol   (pix_eol),
        .count    (occ)
    );

`ifdef FIFO_PIXEL_READER_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= 16'd0;
        else if (pix_valid && !pix_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Directed bench for fifo_pixel_reader (H_ACT=4, V_ACT=2) with a
// behavioural 1-cycle-latency FIFO model.
module tb_fifo_pixel_reader;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         fifo_empty;
    logic [W-1:0] fifo_dout;
    logic         fifo_rd_en;
    logic [W-1:0] pix_data;
    logic         pix_valid;
    logic         pix_ready = 1'b0;
    logic         pix_sof;
    logic         pix_eol;
    logic         busy;
`ifdef FIFO_PIXEL_READER_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    fifo_pixel_reader #(
        .WIDTH (W),
        .H_ACT (4),
        .V_ACT (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
`ifdef FIFO_PIXEL_READER_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model
    logic [W-1:0] mem [64];
    int           wptr = 0;
    int           rptr = 0;
    logic [W-1:0] exp_pix [64];
    int           n_push = 0;

    assign fifo_empty = (wptr == rptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr      <= wptr;
            fifo_dout <= '0;
        end else if (fifo_rd_en) begin
            fifo_dout <= mem[rptr[5:0]];
            rptr      <= rptr + 1;
        end
    end

    task automatic push(input logic [W-1:0] d);
        mem[wptr[5:0]]     = d;
        exp_pix[n_push]    = d;
        n_push++;
        wptr++;
    endtask

    // Monitor: sampled at negedge, inputs change just after posedge
    int           cyc = 0;
    int           rd_cnt = 0;
    int           underflow = 0;
    int           first_rd = -1;
    int           n_out = 0;
    logic [W-1:0] got_data [64];
    logic         got_sof [64];
    logic         got_eol [64];
    int           got_cyc [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_rd_en) begin
                rd_cnt <= rd_cnt + 1;
                if (fifo_empty) underflow <= underflow + 1;
                if (first_rd < 0) first_rd <= cyc;
            end
            if (pix_valid && pix_ready) begin
                got_data[n_out[5:0]] <= pix_data;
                got_sof[n_out[5:0]]  <= pix_sof;
                got_eol[n_out[5:0]]  <= pix_eol;
                got_cyc[n_out[5:0]]  <= cyc;
                n_out <= n_out + 1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_out(input int target, input int budget);
        int k = 0;
        while (n_out < target && k < budget) begin
            step(1);
            k++;
        end
        check("out_count", n_out, target);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step(1);
            k++;
        end
        check("idle_busy", busy, 0);
    endtask

    initial begin
        logic [W-1:0] held;
        int r0;
        int nr;

        // Reset state
        #12;
        check("rst_valid", pix_valid, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_data", pix_data, 0);
        check("rst_sof", pix_sof, 0);
        check("rst_eol", pix_eol, 0);
`ifdef FIFO_PIXEL_READER_STALL_CNT_EN
        check("rst_stall", stall_cnt, 0);
`endif
        step(1);
        rst = 1'b0;
        step(1);

        // Streaming: 8 pixels back to back
        for (int i = 0; i < 8; i++)
            push(24'hA00000 + 24'(i * 3 + 1));
        pix_ready = 1'b1;
        en = 1'b1;
        wait_out(8, 40);
        check("first_lat", got_cyc[0] - first_rd, 2);
        for (int i = 0; i < 8; i++) begin
            check("stream_data", got_data[i], exp_pix[i]);
            check("stream_b2b", got_cyc[i] - got_cyc[0], i);
        end
        en = 1'b0;
        wait_idle(20);

        // Backpressure: 10-cycle stall after 2 of 6 pixels
        for (int i = 8; i < 14; i++)
            push(24'hB00000 + 24'(i * 5));
        en = 1'b1;
        wait_out(10, 40);
        pix_ready = 1'b0;
        held = exp_pix[10];
        repeat (10) begin
            @(negedge clk);
            check("stall_valid", pix_valid, 1);
            check("stall_data", pix_data, held);
            step(1);
        end
        check("stall_buffered", rd_cnt - n_out, 2);
`ifdef FIFO_PIXEL_READER_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 10);
`endif
        pix_ready = 1'b1;
        wait_out(14, 40);
        for (int i = 8; i < 14; i++)
            check("bp_data", got_data[i], exp_pix[i]);
        // Frame tags over the first 9 pixels
        for (int i = 0; i < 9; i++) begin
            check("tag_eol", got_eol[i], (i == 3 || i == 7) ? 1 : 0);
            check("tag_sof", got_sof[i], (i == 0 || i == 8) ? 1 : 0);
        end
        en = 1'b0;
        wait_idle(20);

        // Empty boundary: one pixel, exactly one pop
        r0 = rd_cnt;
        push(24'h00C0DE);
        en = 1'b1;
        step(10);
        check("one_read", rd_cnt - r0, 1);
        check("one_out", n_out, 15);
        check("one_data", got_data[14], exp_pix[14]);
        check("one_empty_rd", fifo_rd_en, 0);
        en = 1'b0;
        wait_idle(20);

        // Stop/restart with two reads outstanding
        r0 = rd_cnt;
        for (int i = 15; i < 19; i++)
            push(24'hD00000 + 24'(i));
        pix_ready = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 20 && rd_cnt - r0 < 2; k++)
            step(1);
        en = 1'b0;
        step(3);
        check("stop_busy", busy, 1);
        check("stop_reads", rd_cnt - r0, 2);
        pix_ready = 1'b1;
        wait_out(17, 20);
        wait_idle(20);
        check("stop_no_more", rd_cnt - r0, 2);
        en = 1'b1;
        wait_out(19, 30);
        for (int i = 15; i < 19; i++)
            check("restart_data", got_data[i], exp_pix[i]);
        check("restart_eol", got_eol[15], 1);
        check("restart_sof15", got_sof[15], 0);
        check("restart_sof16", got_sof[16], 1);

        // Async reset mid-line, between clock edges
        for (int i = 19; i < 25; i++)
            push(24'hE00000 + 24'(i));
        wait_out(21, 30);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", pix_valid, 0);
        check("arst_sof", pix_sof, 0);
        check("arst_busy", busy, 0);
        check("arst_rd_en", fifo_rd_en, 0);
`ifdef FIFO_PIXEL_READER_STALL_CNT_EN
        check("arst_stall", stall_cnt, 0);
`endif
        en = 1'b0;
        step(1);
        rst = 1'b0;
        step(1);
        nr = n_out;
        push(24'hABCDEF);
        push(24'h123456);
        en = 1'b1;
        wait_out(nr + 2, 30);
        check("post_rst_data0", got_data[nr], 24'hABCDEF);
        check("post_rst_sof0", got_sof[nr], 1);
        check("post_rst_data1", got_data[nr + 1], 24'h123456);
        check("post_rst_sof1", got_sof[nr + 1], 0);
        en = 1'b0;
        wait_idle(20);

        check("underflow", underflow, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
